// File: rtl/rm_ihpsg13_bist_pkg.sv
// Shared types for the March C- BIST engine: FSM encoding and the per-element operation table.
package rm_ihpsg13_bist_pkg;

  localparam int unsigned NUM_ELEMS = 6;
  localparam int unsigned ELEM_W    = 3;
  localparam int unsigned ST_W      = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic down;
    logic two_ops;
    logic op0_wr;
    logic op0_val;
    logic op1_wr;
    logic op1_val;
  } march_elem_t;

  // March C-: w0 | up(r0,w1) | up(r1,w0) | down(r0,w1) | down(r1,w0) | r0
  function automatic march_elem_t march_elem(input logic [ELEM_W-1:0] e);
    march_elem_t m;
    m = '0;
    case (e)
      3'd0:    m = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b1, op0_val: 1'b0, op1_wr: 1'b0, op1_val: 1'b0};
      3'd1:    m = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b0, op1_wr: 1'b1, op1_val: 1'b1};
      3'd2:    m = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b1, op1_wr: 1'b1, op1_val: 1'b0};
      3'd3:    m = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b0, op1_wr: 1'b1, op1_val: 1'b1};
      3'd4:    m = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b1, op1_wr: 1'b1, op1_val: 1'b0};
      default: m = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b0, op0_val: 1'b0, op1_wr: 1'b0, op1_val: 1'b0};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rm_ihpsg13_march_bist_if.sv
// BIST port bundle: macro-side A_BIST_* signals plus the test-controller start/status handshake.
interface rm_ihpsg13_march_bist_if #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_ADDR_WIDTH = 9
);
  logic                    A_BIST_START;
  logic                    A_BIST_STOP_ON_FAIL;
  logic                    A_BIST_EN;
  logic                    A_BIST_MEN;
  logic                    A_BIST_WEN;
  logic                    A_BIST_REN;
  logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
  logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
  logic [P_DATA_WIDTH-1:0] A_BIST_BM;
  logic [P_DATA_WIDTH-1:0] A_BIST_DOUT;
  logic                    A_BIST_BUSY;
  logic                    A_BIST_DONE;
  logic                    A_BIST_FAIL;
  logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR;
  logic [2:0]              A_BIST_FAIL_ELEM;
  logic [P_DATA_WIDTH-1:0] A_BIST_FAIL_BITS;

  modport master (
    input  A_BIST_START, A_BIST_STOP_ON_FAIL, A_BIST_DOUT,
    output A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    output A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL, A_BIST_FAIL_ADDR, A_BIST_FAIL_ELEM, A_BIST_FAIL_BITS
  );

  modport slave (
    output A_BIST_START, A_BIST_STOP_ON_FAIL, A_BIST_DOUT,
    input  A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    input  A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL, A_BIST_FAIL_ADDR, A_BIST_FAIL_ELEM, A_BIST_FAIL_BITS
  );
endinterface

// File: rtl/rm_ihpsg13_bist_cmp_pipe.sv
// Read-compare pipeline: delays issued-read context by the macro read latency, then
// compares against DOUT and keeps the sticky fail status.
module rm_ihpsg13_bist_cmp_pipe
  import rm_ihpsg13_bist_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_ADDR_WIDTH = 9,
  parameter int unsigned P_RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    rd_vld,
  input  logic [P_DATA_WIDTH-1:0] rd_exp,
  input  logic [P_ADDR_WIDTH-1:0] rd_addr,
  input  logic [ELEM_W-1:0]       rd_elem,
  input  logic [P_DATA_WIDTH-1:0] dout,
  output logic                    mismatch_c,
  output logic                    fail,
  output logic [P_ADDR_WIDTH-1:0] fail_addr,
  output logic [ELEM_W-1:0]       fail_elem,
  output logic [P_DATA_WIDTH-1:0] fail_bits
);
  localparam int unsigned LAST = P_RD_LAT - 1;

  logic [P_RD_LAT-1:0]     vld_q;
  logic [P_DATA_WIDTH-1:0] exp_q  [P_RD_LAT];
  logic [P_ADDR_WIDTH-1:0] addr_q [P_RD_LAT];
  logic [ELEM_W-1:0]       elem_q [P_RD_LAT];
  logic [P_DATA_WIDTH-1:0] diff_c;

  // Context shift line, one stage per cycle of read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < P_RD_LAT; i++) begin
        exp_q[i]  <= '0;
        addr_q[i] <= '0;
        elem_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= rd_vld;
      exp_q[0]  <= rd_exp;
      addr_q[0] <= rd_addr;
      elem_q[0] <= rd_elem;
      for (int i = 1; i < P_RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        exp_q[i]  <= exp_q[i-1];
        addr_q[i] <= addr_q[i-1];
        elem_q[i] <= elem_q[i-1];
      end
    end
  end

  always_comb begin
    diff_c     = vld_q[LAST] ? (dout ^ exp_q[LAST]) : '0;
    mismatch_c = |diff_c;
  end

  // Address/element are frozen at the first mismatch; the bit map keeps accumulating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_bits <= '0;
    end else if (clr) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_bits <= '0;
    end else if (mismatch_c) begin
      fail_bits <= fail_bits | diff_c;
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= addr_q[LAST];
        fail_elem <= elem_q[LAST];
      end
    end
  end
endmodule

// File: rtl/rm_ihpsg13_march_bist.sv
// March C- BIST engine for single-port SRAM macros: sequences the BIST port and reports
// pass/fail, first failing address/element and the accumulated failing-bit map.
module rm_ihpsg13_march_bist
  import rm_ihpsg13_bist_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_ADDR_WIDTH = 9,
  parameter int unsigned P_RD_LAT     = 1,
  parameter int unsigned P_CKBD       = 0
) (
  input logic                   A_BIST_CLK,
  input logic                   A_BIST_RST_N,
  rm_ihpsg13_march_bist_if.master bist
);
  localparam int unsigned CNT_W = (P_RD_LAT > 1) ? $clog2(P_RD_LAT) : 1;

  logic [ST_W-1:0]         state_q, nxt_state;
  logic [ELEM_W-1:0]       elem_q, nxt_elem;
  logic                    op_q, nxt_op;
  logic [P_ADDR_WIDTH-1:0] addr_q, nxt_addr;
  logic                    stop_q, nxt_stop;
  logic [CNT_W-1:0]        drain_q, nxt_drain;
  logic                    en_q, wen_q, ren_q, busy_q, done_q;
  logic                    nxt_en, nxt_wen, nxt_ren, nxt_busy, nxt_done;
  logic [P_DATA_WIDTH-1:0] din_q, bm_q, exp_q, nxt_din, nxt_bm, nxt_exp;
  logic                    start_c, elem_adv_c, last_op_c, term_c, nxt_wr_c, nxt_val_c, mismatch_c;
  march_elem_t             cur_c, nm_c;

  // Solid background, or checkerboard alternating by bit index and address LSB
  function automatic logic [P_DATA_WIDTH-1:0] bg_word(input logic b, input logic a0);
    logic [P_DATA_WIDTH-1:0] w;
    for (int i = 0; i < P_DATA_WIDTH; i++)
      w[i] = (P_CKBD != 0) ? (b ^ a0 ^ i[0]) : b;
    return w;
  endfunction

  always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
    if (!A_BIST_RST_N) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      stop_q  <= 1'b0;
      drain_q <= '0;
      en_q    <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      din_q   <= '0;
      bm_q    <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= nxt_state;
      elem_q  <= nxt_elem;
      op_q    <= nxt_op;
      addr_q  <= nxt_addr;
      stop_q  <= nxt_stop;
      drain_q <= nxt_drain;
      en_q    <= nxt_en;
      wen_q   <= nxt_wen;
      ren_q   <= nxt_ren;
      busy_q  <= nxt_busy;
      done_q  <= nxt_done;
      din_q   <= nxt_din;
      bm_q    <= nxt_bm;
      exp_q   <= nxt_exp;
    end
  end

  always_comb begin
    nxt_state  = state_q;
    nxt_elem   = elem_q;
    nxt_op     = op_q;
    nxt_addr   = addr_q;
    nxt_stop   = stop_q;
    nxt_drain  = drain_q;
    start_c    = 1'b0;
    elem_adv_c = 1'b0;
    cur_c      = march_elem(elem_q);
    last_op_c  = !cur_c.two_ops || op_q;
    term_c     = cur_c.down ? (addr_q == '0) : (addr_q == '1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bist.A_BIST_START) begin
          start_c   = 1'b1;
          nxt_state = ST_RUN;
          nxt_elem  = '0;
          nxt_op    = 1'b0;
          nxt_addr  = '0;
          nxt_stop  = bist.A_BIST_STOP_ON_FAIL;
        end
      end
      ST_RUN: begin
        if (stop_q && mismatch_c) begin
          nxt_state = ST_DRAIN;
          nxt_drain = '0;
        end else if (!last_op_c) begin
          nxt_op = 1'b1;
        end else if (!term_c) begin
          nxt_op   = 1'b0;
          nxt_addr = cur_c.down ? (addr_q - P_ADDR_WIDTH'(1)) : (addr_q + P_ADDR_WIDTH'(1));
        end else if (elem_q == ELEM_W'(NUM_ELEMS - 1)) begin
          nxt_state = ST_DRAIN;
          nxt_drain = '0;
        end else begin
          nxt_elem   = elem_q + ELEM_W'(1);
          nxt_op     = 1'b0;
          elem_adv_c = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == CNT_W'(P_RD_LAT - 1)) nxt_state = ST_DONE;
        else                                 nxt_drain = drain_q + CNT_W'(1);
      end
      default: nxt_state = ST_IDLE;
    endcase

    // Registered outputs are derived from the next operation
    nm_c = march_elem(nxt_elem);
    if (elem_adv_c) nxt_addr = nm_c.down ? '1 : '0;
    nxt_wr_c  = nxt_op ? nm_c.op1_wr  : nm_c.op0_wr;
    nxt_val_c = nxt_op ? nm_c.op1_val : nm_c.op0_val;
    nxt_exp   = bg_word(nxt_val_c, nxt_addr[0]);
    nxt_en    = (nxt_state == ST_RUN) || (nxt_state == ST_DRAIN);
    nxt_busy  = nxt_en;
    nxt_done  = (nxt_state == ST_DONE);
    nxt_wen   = (nxt_state == ST_RUN) && nxt_wr_c;
    nxt_ren   = (nxt_state == ST_RUN) && !nxt_wr_c;
    nxt_din   = nxt_wen ? nxt_exp : '0;
    nxt_bm    = nxt_wen ? '1 : '0;
  end

  rm_ihpsg13_bist_cmp_pipe #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_ADDR_WIDTH (P_ADDR_WIDTH),
    .P_RD_LAT     (P_RD_LAT)
  ) u_cmp_pipe (
    .clk        (A_BIST_CLK),
    .rst_n      (A_BIST_RST_N),
    .clr        (start_c),
    .rd_vld     (ren_q),
    .rd_exp     (exp_q),
    .rd_addr    (addr_q),
    .rd_elem    (elem_q),
    .dout       (bist.A_BIST_DOUT),
    .mismatch_c (mismatch_c),
    .fail       (bist.A_BIST_FAIL),
    .fail_addr  (bist.A_BIST_FAIL_ADDR),
    .fail_elem  (bist.A_BIST_FAIL_ELEM),
    .fail_bits  (bist.A_BIST_FAIL_BITS)
  );

  assign bist.A_BIST_EN   = en_q;
  assign bist.A_BIST_MEN  = en_q;
  assign bist.A_BIST_WEN  = wen_q;
  assign bist.A_BIST_REN  = ren_q;
  assign bist.A_BIST_ADDR = addr_q;
  assign bist.A_BIST_DIN  = din_q;
  assign bist.A_BIST_BM   = bm_q;
  assign bist.A_BIST_BUSY = busy_q;
  assign bist.A_BIST_DONE = done_q;
endmodule
